// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Purpose  : Shared types and constants for the DHT11 single-wire controller:
//            FSM state encoding, microsecond-to-cycle conversion, default
//            cycle counts at 50 MHz and frame byte positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_WAIT_RESP = 3'd1,
    ST_RESP_LOW  = 3'd2,
    ST_RESP_HIGH = 3'd3,
    ST_BIT_LOW   = 3'd4,
    ST_BIT_HIGH  = 3'd5,
    ST_FINISH    = 3'd6,
    ST_IDLE      = 3'd7
  } state_t;

  // 40-bit frame, MSB first: hum_int, hum_dec, temp_int, temp_dec, checksum.
  localparam int FRAME_BITS = 40;
  localparam int HUM_LSB    = 32;
  localparam int TEMP_LSB   = 16;

  // 64-bit intermediate so 20 ms at 50 MHz does not overflow.
  function automatic int us_to_cycles(input int us, input int clk_hz);
    longint prod;
    prod = longint'(us) * longint'(clk_hz);
    return int'(prod / 64'sd1_000_000);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Cycle counts for the default 50 MHz configuration.
  localparam int DEF_START_CYC  = us_to_cycles(20_000, 50_000_000);
  localparam int DEF_IDLE_CYC   = us_to_cycles(20_000, 50_000_000);
  localparam int DEF_RESP_CYC   = us_to_cycles(5_000, 50_000_000);
  localparam int DEF_SAMPLE_CYC = us_to_cycles(40, 50_000_000);
  localparam int DEF_PHASE_CYC  = us_to_cycles(200, 50_000_000);

endpackage
`default_nettype wire

// File: rtl/dht11_sync.sv
`default_nettype none
// ============================================================================
// Module   : dht11_sync
// Purpose  : Two-flop synchronizer for the DHT11 data line. Anything other
//            than a solid 0 (1, Z, X) is treated as a released, pulled-up line.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset (output forced high)
//            din  - raw data line from the pad
//            dout - synchronized line level
// Revision : 1.0 - initial release
// ============================================================================
module dht11_sync (
  input  logic clk,
  input  logic rst,
  input  wire  din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= (din === 1'b0) ? 1'b0 : 1'b1;
      dout <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dht11.sv
`default_nettype none
// ============================================================================
// Module   : dht11
// Purpose  : DHT11 controller. Periodically issues the host start pulse,
//            decodes the 40-bit response and publishes integral humidity and
//            temperature bytes.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            w1   - open-drain data line (driven 0 or released)
//            done - fresh frame valid, until the next start pulse begins
//            temp - integral temperature (frame byte 2)
//            hum  - integral humidity (frame byte 0)
// Revision : 1.0 - initial release
// ============================================================================
module dht11
  import dht11_pkg::*;
#(
  parameter int CLK_HZ           = 50_000_000,
  parameter int START_LOW_US     = 20_000,
  parameter int IDLE_US          = 20_000,
  parameter int RESP_TIMEOUT_US  = 5_000,
  parameter int BIT_SAMPLE_US    = 40,
  parameter int PHASE_TIMEOUT_US = 200
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        w1,
  output logic       done,
  output logic [7:0] temp,
  output logic [7:0] hum
);

  localparam int START_CYC  = us_to_cycles(START_LOW_US, CLK_HZ);
  localparam int IDLE_CYC   = us_to_cycles(IDLE_US, CLK_HZ);
  localparam int RESP_CYC   = us_to_cycles(RESP_TIMEOUT_US, CLK_HZ);
  localparam int SAMPLE_CYC = us_to_cycles(BIT_SAMPLE_US, CLK_HZ);
  localparam int PHASE_CYC  = us_to_cycles(PHASE_TIMEOUT_US, CLK_HZ);
  localparam int MAX_CYC    = max2(max2(START_CYC, IDLE_CYC), max2(RESP_CYC, PHASE_CYC));
  localparam int CNT_W      = $clog2(MAX_CYC + 1) + 1;

  localparam logic [CNT_W-1:0] START_CNT  = CNT_W'(START_CYC);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESP_CYC - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_CYC);
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [5:0]       LAST_BIT   = 6'(FRAME_BITS - 1);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [5:0]              bit_idx;
  logic [FRAME_BITS-1:0]   frame;
  logic                    sampled;
  logic                    armed;
  logic                    drive_low;
  logic                    line;

  assign w1 = drive_low ? 1'b0 : 1'bz;

  dht11_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (w1),
    .dout (line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_START;
      cnt       <= '0;
      bit_idx   <= '0;
      frame     <= '0;
      sampled   <= 1'b0;
      armed     <= 1'b0;
      drive_low <= 1'b0;
      done      <= 1'b0;
      temp      <= '0;
      hum       <= '0;
    end else begin
      case (state)
        // drive_low rises on the first START cycle, so the pulse is exactly
        // START_CYC long whether START was entered from reset or from IDLE.
        ST_START: begin
          if (cnt == START_CNT) begin
            drive_low <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            state     <= ST_WAIT_RESP;
          end else begin
            drive_low <= 1'b1;
            cnt       <= cnt + 1'b1;
          end
        end

        // The synchronizer still shows our own start pulse for a couple of
        // cycles after release; only accept a low once the line was seen high.
        ST_WAIT_RESP: begin
          if (armed && !line) begin
            cnt   <= '0;
            state <= ST_RESP_LOW;
          end else if (cnt == RESP_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (line) armed <= 1'b1;
          end
        end

        ST_RESP_LOW: begin
          if (line) begin
            cnt   <= '0;
            state <= ST_RESP_HIGH;
          end else if (cnt == PHASE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP_HIGH: begin
          if (!line) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= ST_BIT_LOW;
          end else if (cnt == PHASE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_BIT_LOW: begin
          if (line) begin
            cnt     <= '0;
            sampled <= 1'b0;
            state   <= ST_BIT_HIGH;
          end else if (cnt == PHASE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A bit is decided either by an early falling edge (0) or by the
        // line level at the sample point; in both cases 'line' is the bit.
        ST_BIT_HIGH: begin
          if (!sampled && (!line || cnt == SAMPLE_CNT)) begin
            frame   <= {frame[FRAME_BITS-2:0], line};
            sampled <= 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= ST_FINISH;
            end else if (!line) begin
              cnt     <= '0;
              bit_idx <= bit_idx + 1'b1;
              state   <= ST_BIT_LOW;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (sampled && !line) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
            state   <= ST_BIT_LOW;
          end else if (cnt == PHASE_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_FINISH: begin
          hum   <= frame[HUM_LSB +: 8];
          temp  <= frame[TEMP_LSB +: 8];
          done  <= 1'b1;
          cnt   <= '0;
          state <= ST_IDLE;
        end

        ST_IDLE: begin
          if (cnt == IDLE_LAST) begin
            cnt   <= '0;
            done  <= 1'b0;
            state <= ST_START;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dht11.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11
// Purpose  : Directed bench for dht11 with a cycle-based DHT11 sensor model.
//            Timing is scaled to 1 cycle per microsecond with shortened start,
//            idle and response windows.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dht11;

  localparam int START_CYC = 1000;
  localparam int IDLE_CYC  = 1000;
  localparam int RESP_CYC  = 500;
  localparam int LIMIT     = 5000;

  logic       clk = 1'b0;
  logic       rst;
  logic       sens_low;
  wire        w1;
  logic       done;
  logic [7:0] temp;
  logic [7:0] hum;

  int checks   = 0;
  int failures = 0;
  int gap;
  int width;

  always #5 clk = ~clk;

  assign w1 = sens_low ? 1'b0 : 1'bz;
  pullup (w1);

  dht11 #(
    .CLK_HZ           (1_000_000),
    .START_LOW_US     (START_CYC),
    .IDLE_US          (IDLE_CYC),
    .RESP_TIMEOUT_US  (RESP_CYC),
    .BIT_SAMPLE_US    (40),
    .PHASE_TIMEOUT_US (200)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .w1   (w1),
    .done (done),
    .temp (temp),
    .hum  (hum)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts high samples until the line goes low, then low samples until it
  // is released again. Returns on the first released sample.
  task automatic wait_pulse(output int g, output int w);
    g = 0;
    w = 0;
    @(negedge clk);
    while (w1 !== 1'b0 && g < LIMIT) begin
      g++;
      @(negedge clk);
    end
    while (w1 === 1'b0 && w < LIMIT) begin
      w++;
      @(negedge clk);
    end
  endtask

  // mode 0: full frame; mode 1: release line for good at the start of the
  // high phase of bit at_bit; mode 2: return 10 cycles into that high phase.
  task automatic send_frame(input logic [39:0] data, input int mode, input int at_bit);
    repeat (100) @(negedge clk);
    sens_low = 1'b1; repeat (80) @(negedge clk);
    sens_low = 1'b0; repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      sens_low = 1'b1; repeat (50) @(negedge clk);
      sens_low = 1'b0;
      if (mode == 1 && i == at_bit) return;
      if (mode == 2 && i == at_bit) begin
        repeat (10) @(negedge clk);
        return;
      end
      repeat (data[39 - i] ? 70 : 28) @(negedge clk);
    end
    sens_low = 1'b1; repeat (50) @(negedge clk);
    sens_low = 1'b0; repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    sens_low = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_hum", {24'd0, hum}, 32'd0);
    check_eq("rst_temp", {24'd0, temp}, 32'd0);
    check_eq("rst_w1_released", {31'd0, w1}, 32'd1);
    rst = 1'b0;

    // First start pulse and frame DD CD 35 DD CD
    wait_pulse(gap, width);
    check_eq("start1_width", width, START_CYC);
    send_frame(40'hDD_CD_35_DD_CD, 0, 0);
    check_eq("f1_done", {31'd0, done}, 32'd1);
    check_eq("f1_hum", {24'd0, hum}, 32'hDD);
    check_eq("f1_temp", {24'd0, temp}, 32'h35);

    // Second frame 71 CD 53 DD CD
    wait_pulse(gap, width);
    check_eq("start2_done_clr", {31'd0, done}, 32'd0);
    check_eq("start2_width", width, START_CYC);
    send_frame(40'h71_CD_53_DD_CD, 0, 0);
    check_eq("f2_done", {31'd0, done}, 32'd1);
    check_eq("f2_hum", {24'd0, hum}, 32'h71);
    check_eq("f2_temp", {24'd0, temp}, 32'h53);

    // No sensor response: response timeout, idle, then a new pulse
    wait_pulse(gap, width);
    wait_pulse(gap, width);
    check_eq("noresp_gap", {31'd0, (gap >= RESP_CYC + IDLE_CYC - 1 && gap <= RESP_CYC + IDLE_CYC + 2)}, 32'd1);
    check_eq("noresp_width", width, START_CYC);
    check_eq("noresp_hum", {24'd0, hum}, 32'h71);
    check_eq("noresp_temp", {24'd0, temp}, 32'h53);
    check_eq("noresp_done", {31'd0, done}, 32'd0);

    // Line stuck high during bit 10: phase timeout, nothing published
    send_frame(40'h2A_00_19_00_43, 1, 10);
    repeat (300) @(negedge clk);
    check_eq("stuck_hum", {24'd0, hum}, 32'h71);
    check_eq("stuck_temp", {24'd0, temp}, 32'h53);
    check_eq("stuck_done", {31'd0, done}, 32'd0);

    // Recovery frame 2A 00 19 00 43
    wait_pulse(gap, width);
    check_eq("start4_width", width, START_CYC);
    send_frame(40'h2A_00_19_00_43, 0, 0);
    check_eq("f3_done", {31'd0, done}, 32'd1);
    check_eq("f3_hum", {24'd0, hum}, 32'h2A);
    check_eq("f3_temp", {24'd0, temp}, 32'h19);

    // Reset during bit 20
    wait_pulse(gap, width);
    send_frame(40'h71_CD_53_DD_CD, 2, 20);
    rst = 1'b1;
    sens_low = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_done", {31'd0, done}, 32'd0);
    check_eq("midrst_hum", {24'd0, hum}, 32'd0);
    check_eq("midrst_temp", {24'd0, temp}, 32'd0);
    check_eq("midrst_w1_released", {31'd0, w1}, 32'd1);
    rst = 1'b0;
    wait_pulse(gap, width);
    check_eq("midrst_start_width", width, START_CYC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
